// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: bus widths, reset PC and bus payload layouts.
package if_stage_pkg;

  localparam int unsigned PC_WD           = 32;
  localparam int unsigned BR_BUS_WD       = 33;
  localparam int unsigned FS_TO_DS_BUS_WD = 64;

  localparam logic [PC_WD-1:0] RESET_PC = 32'h1c00_0000;
  localparam logic [PC_WD-1:0] PC_STEP  = 32'd4;

  // Branch redirect from decode
  typedef struct packed {
    logic             taken;
    logic [PC_WD-1:0] target;
  } br_bus_t;

  // Instruction handed to decode
  typedef struct packed {
    logic [PC_WD-1:0] pc;
    logic [PC_WD-1:0] inst;
  } fs_to_ds_t;

endpackage

// File: rtl/if_stage_fs_inst_buf.sv
// Single-entry instruction buffer with its valid bit and the response-cancel flag.
module fs_inst_buf
  import if_stage_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             fill_en,
  input  logic [PC_WD-1:0] fill_data,
  input  logic             drain_en,
  input  logic             cancel_set,
  input  logic             cancel_clr,
  output logic [PC_WD-1:0] inst,
  output logic             valid,
  output logic             cancel
);

  logic [PC_WD-1:0] inst_q, inst_d;
  logic             valid_q, valid_d;
  logic             cancel_q, cancel_d;

  // Fill takes priority over drain; both never coincide in practice
  always_comb begin
    inst_d   = inst_q;
    valid_d  = valid_q;
    cancel_d = cancel_q;
    if (fill_en) begin
      inst_d  = fill_data;
      valid_d = 1'b1;
    end else if (drain_en) begin
      valid_d = 1'b0;
    end
    if (cancel_set) begin
      cancel_d = 1'b1;
    end else if (cancel_clr) begin
      cancel_d = 1'b0;
    end
  end

  // Buffer state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q   <= '0;
      valid_q  <= 1'b0;
      cancel_q <= 1'b0;
    end else begin
      inst_q   <= inst_d;
      valid_q  <= valid_d;
      cancel_q <= cancel_d;
    end
  end

  assign inst   = inst_q;
  assign valid  = valid_q;
  assign cancel = cancel_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: pc generation, one-outstanding SRAM request FSM, redirect handling.
module if_stage
  import if_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_req,
  output logic [PC_WD-1:0]           inst_sram_addr,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [PC_WD-1:0]           inst_sram_rdata
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } fs_state_e;

  fs_state_e        state_q, state_d;
  logic [PC_WD-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WD-1:0] pend_target_q, pend_target_d;
  logic             pend_valid_q, pend_valid_d;

  br_bus_t          br;
  fs_to_ds_t        fs_bus;
  logic [PC_WD-1:0] nextpc;
  logic             br_fire, in_wait, in_hold, handoff, resp_drop, empty_next, accept;
  logic             buf_fill, buf_drain, cancel_set, cancel_clr;
  logic [PC_WD-1:0] buf_inst;
  logic             buf_valid, buf_cancel;

  assign br = br_bus;

  // Handshake qualifiers, next pc and request generation
  always_comb begin
    br_fire        = br.taken & ds_allowin;
    in_wait        = (state_q == S_WAIT);
    in_hold        = (state_q == S_HOLD);
    fs_to_ds_valid = in_hold & buf_valid & ~br.taken;
    handoff        = fs_to_ds_valid & ds_allowin;
    // A response that arrives already cancelled, or alongside a redirect, is wrong-path
    resp_drop      = in_wait & inst_sram_data_ok & (buf_cancel | br_fire);
    case (state_q)
      S_EMPTY: empty_next = 1'b1;
      S_WAIT:  empty_next = resp_drop;
      S_HOLD:  empty_next = handoff | br_fire;
      default: empty_next = 1'b1;
    endcase
    nextpc = fetch_pc_q + PC_STEP;
    if (pend_valid_q) nextpc = pend_target_q;
    if (br_fire)      nextpc = br.target;
    // A branch stalled in decode holds fetch so its target is not lost behind a wrong-path fetch
    inst_sram_req  = ~reset & empty_next & ~(br.taken & ~ds_allowin);
    inst_sram_addr = nextpc;
    accept         = inst_sram_req & inst_sram_addr_ok;
    buf_fill       = in_wait & inst_sram_data_ok & ~resp_drop;
    buf_drain      = in_hold & empty_next;
    cancel_set     = in_wait & br_fire & ~inst_sram_data_ok;
    cancel_clr     = in_wait & inst_sram_data_ok & buf_cancel;
  end

  // FSM next state, pc capture and pending redirect target
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if (accept) fetch_pc_d = nextpc;
    if (br_fire && !accept) begin
      pend_valid_d  = 1'b1;
      pend_target_d = br.target;
    end else if (accept) begin
      pend_valid_d  = 1'b0;
    end
    case (state_q)
      S_EMPTY: if (accept) state_d = S_WAIT;
      S_WAIT: begin
        if (inst_sram_data_ok) begin
          if (resp_drop) state_d = accept ? S_WAIT : S_EMPTY;
          else           state_d = S_HOLD;
        end
      end
      S_HOLD:  if (empty_next) state_d = accept ? S_WAIT : S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // State registers; fetch_pc resets one step behind the reset PC
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_EMPTY;
      fetch_pc_q    <= RESET_PC - PC_STEP;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  fs_inst_buf u_inst_buf (
    .clk        (clk),
    .reset      (reset),
    .fill_en    (buf_fill),
    .fill_data  (inst_sram_rdata),
    .drain_en   (buf_drain),
    .cancel_set (cancel_set),
    .cancel_clr (cancel_clr),
    .inst       (buf_inst),
    .valid      (buf_valid),
    .cancel     (buf_cancel)
  );

  // Decode-facing payload: pc of the last accepted request with its buffered word
  always_comb begin
    fs_bus.pc   = fetch_pc_q;
    fs_bus.inst = buf_inst;
  end

  assign fs_to_ds_bus = fs_bus;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: table-driven cycle vectors with an SRAM responder and two scoreboards.
module tb_if_stage;
  import if_stage_pkg::*;

  logic                       clk;
  logic                       reset;
  logic                       ds_allowin;
  logic [BR_BUS_WD-1:0]       br_bus;
  logic                       fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  logic                       inst_sram_req;
  logic [PC_WD-1:0]           inst_sram_addr;
  logic                       inst_sram_addr_ok;
  logic                       inst_sram_data_ok;
  logic [PC_WD-1:0]           inst_sram_rdata;

  if_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ds_allowin        (ds_allowin),
    .br_bus            (br_bus),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] R = 32'h1c00_0000;

  typedef struct {
    logic        rst;
    logic        allowin;
    logic        bt;
    logic [31:0] tgt;
    logic        ok;
    int          lat;
    logic        ovr;
    logic        drop;
    logic        er;
    logic [31:0] ea;
    logic        ev;
    logic        chk_bus;
    logic [63:0] exp_bus;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] acc_q[$];
  logic [63:0] ho_q[$];
  int          ho_cyc_q[$];

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          ho_cnt = 0;
  bit          out_v = 1'b0;
  int          out_cnt = 0;
  logic [31:0] out_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input int rst, input int a, input int bt, input logic [31:0] tgt,
                              input int ok, input int lat, input int ovr, input int drop,
                              input int er, input logic [31:0] ea, input int ev);
    vec_t v;
    v.rst = (rst != 0);  v.allowin = (a != 0);  v.bt = (bt != 0);  v.tgt = tgt;
    v.ok = (ok != 0);    v.lat = lat;           v.ovr = (ovr != 0); v.drop = (drop != 0);
    v.er = (er != 0);    v.ea = ea;             v.ev = (ev != 0);
    v.chk_bus = 1'b0;    v.exp_bus = '0;
    return v;
  endfunction

  task automatic add(input int rst, input int a, input int bt, input logic [31:0] tgt,
                     input int ok, input int lat, input int ovr, input int drop,
                     input int er, input logic [31:0] ea, input int ev);
    tbl.push_back(mk(rst, a, bt, tgt, ok, lat, ovr, drop, er, ea, ev));
  endtask

  task automatic add_bus(input logic [63:0] b);
    tbl[tbl.size()-1].chk_bus = 1'b1;
    tbl[tbl.size()-1].exp_bus = b;
  endtask

  // One clock: drive the row, let the responder answer, check outputs, then advance
  task automatic apply(input vec_t v, input int idx);
    logic        acc;
    logic [31:0] acc_addr;
    logic [63:0] e;
    @(negedge clk);
    reset             = v.rst;
    ds_allowin        = v.allowin;
    br_bus            = {v.bt, v.tgt};
    inst_sram_addr_ok = v.ok;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = '0;
    if (out_v && out_cnt == 0) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = v.ovr ? 32'hdead_beef : ~out_addr;
      if (!v.drop) ho_q.push_back({out_addr, inst_sram_rdata});
    end
    if (v.er && v.ok) acc_q.push_back(v.ea);
    #1;
    chk($sformatf("req[%0d]", idx), 64'(inst_sram_req), 64'(v.er));
    if (v.er) chk($sformatf("addr[%0d]", idx), 64'(inst_sram_addr), 64'(v.ea));
    chk($sformatf("valid[%0d]", idx), 64'(fs_to_ds_valid), 64'(v.ev));
    if (fs_to_ds_valid)
      chk($sformatf("no_wrong_path[%0d]", idx), 64'(fs_to_ds_bus[31:0] == 32'hdead_beef), 64'd0);
    if (v.chk_bus) chk($sformatf("bus_stable[%0d]", idx), fs_to_ds_bus, v.exp_bus);
    acc      = inst_sram_req & inst_sram_addr_ok;
    acc_addr = inst_sram_addr;
    if (acc) begin
      if (acc_q.size() == 0) chk($sformatf("unexpected_accept[%0d]", idx), 64'(acc_addr), 64'hx);
      else begin
        e = 64'(acc_q.pop_front());
        chk($sformatf("accept_addr[%0d]", idx), 64'(acc_addr), e);
      end
    end
    if (fs_to_ds_valid && ds_allowin) begin
      ho_cnt++;
      ho_cyc_q.push_back(cyc);
      if (ho_q.size() == 0) chk($sformatf("unexpected_handoff[%0d]", idx), fs_to_ds_bus, 64'hx);
      else begin
        e = ho_q.pop_front();
        chk($sformatf("handoff[%0d]", idx), fs_to_ds_bus, e);
      end
    end
    @(posedge clk);
    if (inst_sram_data_ok) out_v = 1'b0;
    else if (out_v && out_cnt > 0) out_cnt--;
    if (v.rst) out_v = 1'b0;
    if (acc) begin
      out_v    = 1'b1;
      out_addr = acc_addr;
      out_cnt  = v.lat - 1;
    end
    cyc++;
  endtask

  initial begin
    int ho0;
    int c0;
    vec_t v;
    reset = 1'b1; ds_allowin = 1'b1; br_bus = '0;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;
    repeat (2) @(posedge clk);

    // rst a bt tgt ok lat ovr drop | req addr valid
    add(1,1,0,0,0,1,0,0, 0,0,0);
    // Decode stall while holding: bus frozen, no request
    add(0,1,0,0,1,1,0,0, 1,R,0);
    add(0,1,0,0,1,1,0,0, 0,0,0);
    for (int i = 0; i < 5; i++) begin
      add(0,0,0,0,1,1,0,0, 0,0,1);
      add_bus({R, ~R});
    end
    add(0,1,0,0,1,1,0,0, 1,R+4,1);
    add(0,1,0,0,0,1,0,0, 0,0,0);
    add(0,1,0,0,0,1,0,0, 1,R+8,1);
    add(1,1,0,0,0,1,0,0, 0,0,0);
    // Branch stalled in decode, then fires: held entry discarded
    add(0,1,0,0,1,1,0,0, 1,R,0);
    add(0,1,0,0,1,1,0,1, 0,0,0);
    for (int i = 0; i < 3; i++) add(0,0,1,32'h1c00_0100,1,1,0,0, 0,0,0);
    add(0,1,1,32'h1c00_0100,1,1,0,0, 1,32'h1c00_0100,0);
    add(0,1,0,0,0,1,0,0, 0,0,0);
    add(0,1,0,0,0,1,0,0, 1,32'h1c00_0104,1);
    add(1,1,0,0,0,1,0,0, 0,0,0);
    // Redirect while waiting: late response dropped, target fetched after it
    add(0,1,0,0,1,3,0,0, 1,R,0);
    add(0,1,1,32'h1c00_0300,1,1,0,0, 0,0,0);
    add(0,1,0,0,1,1,0,0, 0,0,0);
    add(0,1,0,0,1,1,1,1, 1,32'h1c00_0300,0);
    add(0,1,0,0,0,1,0,0, 0,0,0);
    add(0,1,0,0,0,1,0,0, 1,32'h1c00_0304,1);
    add(1,1,0,0,0,1,0,0, 0,0,0);
    // Redirect coincident with response, target not accepted for two cycles
    add(0,1,0,0,1,1,0,0, 1,R,0);
    add(0,1,1,32'h1c00_0200,0,1,0,1, 1,32'h1c00_0200,0);
    add(0,1,0,0,0,1,0,0, 1,32'h1c00_0200,0);
    add(0,1,0,0,1,1,0,0, 1,32'h1c00_0200,0);
    add(0,1,0,0,0,1,0,0, 0,0,0);
    add(0,1,0,0,0,1,0,0, 1,32'h1c00_0204,1);
    add(1,1,0,0,0,1,0,0, 0,0,0);
    // Reset while waiting, response lands in the reset cycle
    add(0,1,0,0,1,1,0,0, 1,R,0);
    add(1,1,0,0,1,1,0,1, 0,0,0);
    add(0,1,0,0,1,1,0,0, 1,R,0);
    add(0,1,0,0,0,1,0,0, 0,0,0);
    add(0,1,0,0,0,1,0,0, 1,R+4,1);
    add(1,1,0,0,0,1,0,0, 0,0,0);
    // PC wraps past the top of the address space
    add(0,1,0,0,1,1,0,0, 1,R,0);
    add(0,1,0,0,0,1,0,1, 0,0,0);
    add(0,1,1,32'hffff_fffc,1,1,0,0, 1,32'hffff_fffc,0);
    add(0,1,0,0,1,1,0,0, 0,0,0);
    add(0,1,0,0,1,1,0,0, 1,32'h0000_0000,1);
    add(0,1,0,0,0,1,0,0, 0,0,0);
    add(0,1,0,0,0,1,0,0, 1,32'h0000_0004,1);
    add(1,1,0,0,0,1,0,0, 0,0,0);

    foreach (tbl[i]) apply(tbl[i], i);

    // Streaming fetch: one instruction every two cycles from the reset PC
    ho0 = ho_cnt;
    ho_cyc_q.delete();
    c0 = cyc;
    for (int i = 0; i < 11; i++) begin
      v = mk(0, 1, 0, 0, (i < 10) ? 1 : 0, 1, 0, 0,
             (i % 2 == 0) ? 1 : 0, R + 32'(4 * (i / 2)), (i >= 2 && i % 2 == 0) ? 1 : 0);
      apply(v, 100 + i);
    end
    chk("stream_count", 64'(ho_cnt - ho0), 64'd5);
    if (ho_cyc_q.size() > 0) chk("stream_first_latency", 64'(ho_cyc_q[0] - c0), 64'd2);
    for (int k = 1; k < ho_cyc_q.size(); k++)
      chk($sformatf("stream_gap[%0d]", k), 64'(ho_cyc_q[k] - ho_cyc_q[k-1]), 64'd2);

    chk("accepts_outstanding", 64'(acc_q.size()), 64'd0);
    chk("handoffs_outstanding", 64'(ho_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
